// File: rtl/bvh_leaf_prim_iterator_if.sv
// Handshake bundle between leaf decode, primitive intersection and traversal control.
// leaf_any_hit exists only when BVH_LEAF_ANY_HIT_EN is defined.
interface bvh_leaf_prim_iterator_if #(
    parameter int unsigned PRIM_INDEX_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH      = 8,
    parameter int unsigned T_WIDTH          = 32
);
    logic                        leaf_valid;
    logic                        leaf_ready;
    logic [PRIM_INDEX_WIDTH-1:0] leaf_start_prim;
    logic [COUNT_WIDTH-1:0]      leaf_num_prims;
    logic [T_WIDTH-1:0]          leaf_t_max;
`ifdef BVH_LEAF_ANY_HIT_EN
    logic                        leaf_any_hit;
`endif

    logic                        prim_valid;
    logic                        prim_ready;
    logic [PRIM_INDEX_WIDTH-1:0] prim_index;
    logic                        prim_last;

    logic                        isect_valid;
    logic                        isect_hit;
    logic [T_WIDTH-1:0]          isect_t;
    logic [PRIM_INDEX_WIDTH-1:0] isect_prim;

    logic                        done_valid;
    logic                        done_ready;
    logic                        done_hit;
    logic [T_WIDTH-1:0]          done_t;
    logic [PRIM_INDEX_WIDTH-1:0] done_prim;

    // Iterator side
    modport slave (
        input  leaf_valid, leaf_start_prim, leaf_num_prims, leaf_t_max,
`ifdef BVH_LEAF_ANY_HIT_EN
        input  leaf_any_hit,
`endif
        output leaf_ready,
        output prim_valid, prim_index, prim_last,
        input  prim_ready,
        input  isect_valid, isect_hit, isect_t, isect_prim,
        output done_valid, done_hit, done_t, done_prim,
        input  done_ready
    );

    // Environment side
    modport master (
        output leaf_valid, leaf_start_prim, leaf_num_prims, leaf_t_max,
`ifdef BVH_LEAF_ANY_HIT_EN
        output leaf_any_hit,
`endif
        input  leaf_ready,
        input  prim_valid, prim_index, prim_last,
        output prim_ready,
        output isect_valid, isect_hit, isect_t, isect_prim,
        input  done_valid, done_hit, done_t, done_prim,
        output done_ready
    );
endinterface

// File: rtl/bvh_leaf_prim_iterator.sv
// Walks one BVH leaf's primitive range, issues indices and reduces returned hits to the closest one.
// Optional BVH_LEAF_ANY_HIT_EN: stop issuing after the first accepted hit (shadow rays).
module bvh_leaf_prim_iterator #(
    parameter int unsigned PRIM_INDEX_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH      = 8,
    parameter int unsigned T_WIDTH          = 32
) (
    input logic                     clk,
    input logic                     resetn,
    bvh_leaf_prim_iterator_if.slave bus
);
    localparam int unsigned OUT_WIDTH = COUNT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic [COUNT_WIDTH-1:0]      remaining;
    logic [OUT_WIDTH-1:0]        outstanding;
    logic [T_WIDTH-1:0]          best_t;
    logic                        best_hit;
    logic [PRIM_INDEX_WIDTH-1:0] best_prim;
`ifdef BVH_LEAF_ANY_HIT_EN
    logic                        any_hit;
`endif

    logic                 busy_c;
    logic                 prim_fire_c;
    logic                 ret_c;
    logic                 better_c;
    logic                 stop_c;
    logic [OUT_WIDTH-1:0] out_next_c;

    // Handshake decode, closest-hit compare and in-flight bookkeeping
    always_comb begin
        busy_c      = (state == ISSUE) || (state == DRAIN);
        prim_fire_c = (state == ISSUE) && bus.prim_valid && bus.prim_ready;
        ret_c       = busy_c && bus.isect_valid && (outstanding != '0);
        better_c    = busy_c && bus.isect_valid && bus.isect_hit &&
                      ($signed(bus.isect_t) < $signed(best_t));
        out_next_c  = outstanding + OUT_WIDTH'(prim_fire_c) - OUT_WIDTH'(ret_c);
        stop_c      = 1'b0;
`ifdef BVH_LEAF_ANY_HIT_EN
        stop_c      = any_hit && (best_hit || better_c);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            remaining      <= '0;
            outstanding    <= '0;
            best_t         <= '0;
            best_hit       <= 1'b0;
            best_prim      <= '0;
`ifdef BVH_LEAF_ANY_HIT_EN
            any_hit        <= 1'b0;
`endif
            bus.leaf_ready <= 1'b1;
            bus.prim_valid <= 1'b0;
            bus.prim_index <= '0;
            bus.prim_last  <= 1'b0;
            bus.done_valid <= 1'b0;
            bus.done_hit   <= 1'b0;
            bus.done_t     <= '0;
            bus.done_prim  <= '0;
        end else begin
            // Strict less-than keeps the earlier arrival on ties
            if (better_c) begin
                best_t    <= bus.isect_t;
                best_prim <= bus.isect_prim;
                best_hit  <= 1'b1;
            end
            if (busy_c) begin
                outstanding <= out_next_c;
            end

            case (state)
                IDLE: begin
                    if (bus.leaf_valid) begin
                        bus.leaf_ready <= 1'b0;
                        remaining      <= bus.leaf_num_prims;
                        outstanding    <= '0;
                        best_t         <= bus.leaf_t_max;
                        best_hit       <= 1'b0;
                        best_prim      <= '0;
`ifdef BVH_LEAF_ANY_HIT_EN
                        any_hit        <= bus.leaf_any_hit;
`endif
                        if (bus.leaf_num_prims != '0) begin
                            state          <= ISSUE;
                            bus.prim_valid <= 1'b1;
                            bus.prim_index <= bus.leaf_start_prim;
                            bus.prim_last  <= (bus.leaf_num_prims == COUNT_WIDTH'(1));
                        end else begin
                            state          <= DONE;
                            bus.done_valid <= 1'b1;
                            bus.done_hit   <= 1'b0;
                            bus.done_t     <= bus.leaf_t_max;
                            bus.done_prim  <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (prim_fire_c) begin
                        bus.prim_index <= bus.prim_index + PRIM_INDEX_WIDTH'(1);
                        remaining      <= remaining - COUNT_WIDTH'(1);
                        bus.prim_last  <= (remaining == COUNT_WIDTH'(2));
                        if (remaining == COUNT_WIDTH'(1)) begin
                            bus.prim_valid <= 1'b0;
                            state          <= DRAIN;
                        end
                    end
                    if (stop_c) begin
                        bus.prim_valid <= 1'b0;
                        bus.prim_last  <= 1'b0;
                        state          <= DRAIN;
                    end
                end

                // Leave only once every issued index has reported back
                DRAIN: begin
                    if (outstanding == '0) begin
                        state          <= DONE;
                        bus.done_valid <= 1'b1;
                        bus.done_hit   <= best_hit;
                        bus.done_t     <= best_t;
                        bus.done_prim  <= best_prim;
                    end
                end

                DONE: begin
                    if (bus.done_ready) begin
                        state          <= IDLE;
                        bus.done_valid <= 1'b0;
                        bus.leaf_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bvh_leaf_prim_iterator.sv
// Directed bench for bvh_leaf_prim_iterator: latency-table responder, closest-hit model, per-cycle compare.
// Exercises the BVH_LEAF_ANY_HIT_EN scenario when that macro is defined.
module tb_bvh_leaf_prim_iterator;
    localparam int unsigned PW   = 32;
    localparam int unsigned CW   = 8;
    localparam int unsigned TW   = 32;
    localparam int unsigned MAXP = 256;

    typedef struct {
        logic [PW-1:0] prim;
        int            due;
    } pend_t;

    typedef struct {
        logic          hit;
        logic [TW-1:0] t;
        logic [PW-1:0] prim;
    } res_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    int            lat     [MAXP];
    logic          hit_tab [MAXP];
    logic [TW-1:0] t_tab   [MAXP];
    bit            tog_ready  = 1'b0;
    bit            any_sel    = 1'b0;
    int            done_delay = 0;
    int            dcnt       = 0;

    pend_t         pend[$];
    res_t          arr[$];
    logic [PW-1:0] idx_log[$];

    logic [PW-1:0] exp_next;
    logic [TW-1:0] cur_tmax;
    int            exp_num, issued, first_issue, last_issue, accept_cyc, done_cyc;
    bit            done_seen;
    logic          got_hit;
    logic [TW-1:0] got_t;
    logic [PW-1:0] got_prim;

    logic          prev_pv, prev_pr, prev_last, prev_dv, prev_dr, prev_dh;
    logic [PW-1:0] prev_idx, prev_dp;
    logic [TW-1:0] prev_dt;

    bvh_leaf_prim_iterator_if #(.PRIM_INDEX_WIDTH(PW), .COUNT_WIDTH(CW), .T_WIDTH(TW)) bus ();

    bvh_leaf_prim_iterator #(.PRIM_INDEX_WIDTH(PW), .COUNT_WIDTH(CW), .T_WIDTH(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Closest strictly-smaller signed hit over results in arrival order
    function automatic res_t model_result();
        res_t r;
        r.hit  = 1'b0;
        r.t    = cur_tmax;
        r.prim = '0;
        foreach (arr[i]) begin
            if (arr[i].hit && ($signed(arr[i].t) < $signed(r.t))) begin
                r.hit  = 1'b1;
                r.t    = arr[i].t;
                r.prim = arr[i].prim;
            end
        end
        return r;
    endfunction

    // Responder: prim_ready pattern, results by per-offset latency, done_ready after done_delay
    always @(posedge clk) begin : responder
        int   pick;
        res_t r;
        #1;
        bus.prim_ready = tog_ready ? cyc[0] : 1'b1;
        pick = -1;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].due <= cyc && (pick < 0 || pend[i].due < pend[pick].due)) pick = i;
        end
        if (pick >= 0) begin
            r.prim = pend[pick].prim;
            r.hit  = hit_tab[int'(pend[pick].due % 1)];
            r.hit  = hit_tab[int'(r.prim - exp_next + PW'(issued)) % MAXP];
            r.t    = t_tab[int'(r.prim - exp_next + PW'(issued)) % MAXP];
            bus.isect_valid = 1'b1;
            bus.isect_hit   = r.hit;
            bus.isect_t     = r.t;
            bus.isect_prim  = r.prim;
            arr.push_back(r);
            pend.delete(pick);
        end else begin
            bus.isect_valid = 1'b0;
            bus.isect_hit   = 1'b0;
        end
        if (bus.done_valid) dcnt++;
        else dcnt = 0;
        bus.done_ready = bus.done_valid && (dcnt > done_delay);
    end

    // Compare process: issue sequence, stall stability, drain completeness, leaf result
    always @(negedge clk) begin : monitor
        res_t  m;
        pend_t p;
        if (!resetn) begin
            prev_pv = 1'b0;
            prev_dv = 1'b0;
        end else begin
            if (bus.leaf_valid && bus.leaf_ready) accept_cyc = cyc;
            if (bus.prim_valid) begin
                if (prev_pv && !prev_pr) begin
                    check("prim_stable_idx", 64'(bus.prim_index), 64'(prev_idx));
                    check("prim_stable_last", 64'(bus.prim_last), 64'(prev_last));
                end
                if (bus.prim_ready) begin
                    check("prim_index", 64'(bus.prim_index), 64'(exp_next));
                    check("prim_last", 64'(bus.prim_last), 64'(issued + 1 == exp_num));
                    check("prim_in_range", 64'(issued < exp_num), 64'(1));
                    p.prim = bus.prim_index;
                    p.due  = cyc + lat[issued % MAXP];
                    pend.push_back(p);
                    idx_log.push_back(bus.prim_index);
                    if (issued == 0) first_issue = cyc;
                    last_issue = cyc;
                    issued++;
                    exp_next = exp_next + PW'(1);
                end
            end
            if (bus.done_valid) begin
                m = model_result();
                if (!done_seen) begin
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                    check("drain_complete", 64'(pend.size()), 64'(0));
                end
                if (prev_dv && !prev_dr) begin
                    check("done_stable_hit", 64'(bus.done_hit), 64'(prev_dh));
                    check("done_stable_t", 64'(bus.done_t), 64'(prev_dt));
                    check("done_stable_prim", 64'(bus.done_prim), 64'(prev_dp));
                end
                check("done_hit", 64'(bus.done_hit), 64'(m.hit));
                check("done_t", 64'(bus.done_t), 64'(m.t));
                check("done_prim", 64'(bus.done_prim), 64'(m.prim));
                got_hit  = bus.done_hit;
                got_t    = bus.done_t;
                got_prim = bus.done_prim;
            end
            prev_pv   = bus.prim_valid;
            prev_pr   = bus.prim_ready;
            prev_idx  = bus.prim_index;
            prev_last = bus.prim_last;
            prev_dv   = bus.done_valid;
            prev_dr   = bus.done_ready;
            prev_dh   = bus.done_hit;
            prev_dt   = bus.done_t;
            prev_dp   = bus.done_prim;
        end
    end

    task automatic clear_tab(input int l);
        for (int i = 0; i < int'(MAXP); i++) begin
            lat[i]     = l;
            hit_tab[i] = 1'b0;
            t_tab[i]   = '0;
        end
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_leaf_ready"}, 64'(bus.leaf_ready), 64'(1));
        check({tag, "_prim_valid"}, 64'(bus.prim_valid), 64'(0));
        check({tag, "_prim_index"}, 64'(bus.prim_index), 64'(0));
        check({tag, "_prim_last"}, 64'(bus.prim_last), 64'(0));
        check({tag, "_done_valid"}, 64'(bus.done_valid), 64'(0));
        check({tag, "_done_hit"}, 64'(bus.done_hit), 64'(0));
        check({tag, "_done_t"}, 64'(bus.done_t), 64'(0));
        check({tag, "_done_prim"}, 64'(bus.done_prim), 64'(0));
    endtask

    task automatic start_leaf(input logic [PW-1:0] start, input int num, input logic [TW-1:0] tmax);
        int n;
        n = 0;
        while (pend.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("pend_flushed", 64'(pend.size()), 64'(0));
        arr.delete();
        idx_log.delete();
        issued      = 0;
        done_seen   = 1'b0;
        exp_next    = start;
        exp_num     = num;
        cur_tmax    = tmax;
        accept_cyc  = -1;
        first_issue = -1;
        done_cyc    = -1;
        @(posedge clk);
        #1;
        bus.leaf_valid      = 1'b1;
        bus.leaf_start_prim = start;
        bus.leaf_num_prims  = CW'(num);
        bus.leaf_t_max      = tmax;
`ifdef BVH_LEAF_ANY_HIT_EN
        bus.leaf_any_hit    = any_sel;
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.leaf_ready && n < 50);
        check("leaf_accept", 64'(bus.leaf_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.leaf_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(bus.done_valid && bus.done_ready) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 64'(n < 600), 64'(1));
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bus.leaf_valid      = 1'b0;
        bus.leaf_start_prim = '0;
        bus.leaf_num_prims  = '0;
        bus.leaf_t_max      = '0;
`ifdef BVH_LEAF_ANY_HIT_EN
        bus.leaf_any_hit    = 1'b0;
`endif
        bus.prim_ready  = 1'b1;
        bus.isect_valid = 1'b0;
        bus.isect_hit   = 1'b0;
        bus.isect_t     = '0;
        bus.isect_prim  = '0;
        bus.done_ready  = 1'b0;
        clear_tab(1);

        #2 resetn = 1'b0;
        #1 reset_values("rst");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;

        // Three misses, back-to-back issue
        start_leaf(32'h10, 3, 32'h0010_0000);
        wait_done();
        check("t1_first_latency", 64'(first_issue - accept_cyc), 64'(1));
        check("t1_consecutive", 64'(last_issue - first_issue), 64'(2));
        check("t1_issued", 64'(issued), 64'(3));
        check("t1_idx2", 64'(idx_log[2]), 64'h12);
        check("t1_hit", 64'(got_hit), 64'(0));
        check("t1_t", 64'(got_t), 64'h0010_0000);
        check("t1_prim", 64'(got_prim), 64'(0));

        // Empty leaf goes straight to the result
        done_delay = 2;
        start_leaf(32'h99, 0, 32'h5000);
        wait_done();
        check("t2_done_latency", 64'(done_cyc - accept_cyc), 64'(1));
        check("t2_issued", 64'(issued), 64'(0));
        check("t2_hit", 64'(got_hit), 64'(0));
        check("t2_t", 64'(got_t), 64'h5000);

        // Index wrap with a toggling prim_ready
        done_delay = 0;
        clear_tab(2);
        tog_ready = 1'b1;
        start_leaf(32'hFFFF_FFFE, 3, 32'h7FFF_FFFF);
        wait_done();
        tog_ready = 1'b0;
        check("t3_issued", 64'(issued), 64'(3));
        check("t3_idx0", 64'(idx_log[0]), 64'hFFFF_FFFE);
        check("t3_idx1", 64'(idx_log[1]), 64'hFFFF_FFFF);
        check("t3_idx2", 64'(idx_log[2]), 64'h0);

        // Out-of-order returns, tie kept by earlier arrival, return during last issue
        clear_tab(1);
        lat[0] = 4; lat[1] = 1; lat[2] = 1; lat[3] = 1;
        for (int i = 0; i < 4; i++) hit_tab[i] = 1'b1;
        t_tab[0] = 32'h3000; t_tab[1] = 32'h1000; t_tab[2] = 32'h1000; t_tab[3] = 32'h8000;
        done_delay = 1;
        start_leaf(32'h5, 4, 32'h4000);
        wait_done();
        check("t4_order0", 64'(arr[0].prim), 64'h6);
        check("t4_order1", 64'(arr[1].prim), 64'h7);
        check("t4_hit", 64'(got_hit), 64'(1));
        check("t4_t", 64'(got_t), 64'h1000);
        check("t4_prim", 64'(got_prim), 64'h6);

        // Signed distances and the hit flag
        done_delay = 0;
        clear_tab(1);
        hit_tab[0] = 1'b1; t_tab[0] = 32'hFFFF_FFFB;
        hit_tab[1] = 1'b0; t_tab[1] = 32'h8000_0000;
        hit_tab[2] = 1'b1; t_tab[2] = 32'h0000_0001;
        start_leaf(32'd100, 3, 32'h100);
        wait_done();
        check("t5_hit", 64'(got_hit), 64'(1));
        check("t5_t", 64'(got_t), 64'hFFFF_FFFB);
        check("t5_prim", 64'(got_prim), 64'd100);

        // Full-count leaf
        clear_tab(1);
        start_leaf(32'h1000, 255, 32'h10);
        wait_done();
        check("t6_issued", 64'(issued), 64'd255);
        check("t6_last_idx", 64'(idx_log[254]), 64'h10FE);
        check("t6_hit", 64'(got_hit), 64'(0));

        // Reset while draining two outstanding results
        clear_tab(6);
        start_leaf(32'h40, 2, 32'h9000);
        n = 0;
        while (issued < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t7_issued", 64'(issued), 64'(2));
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 reset_values("midrst");
        @(negedge clk);
        #2 resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t7_late_done", 64'(bus.done_valid), 64'(0));
            check("t7_late_ready", 64'(bus.leaf_ready), 64'(1));
        end
        clear_tab(1);
        hit_tab[0] = 1'b1; t_tab[0] = 32'h20;
        start_leaf(32'h77, 1, 32'h9000);
        wait_done();
        check("t7_next_issued", 64'(issued), 64'(1));
        check("t7_next_hit", 64'(got_hit), 64'(1));
        check("t7_next_t", 64'(got_t), 64'h20);
        check("t7_next_prim", 64'(got_prim), 64'h77);

`ifdef BVH_LEAF_ANY_HIT_EN
        // Any-hit leaf stops issuing after the first hit
        clear_tab(1);
        hit_tab[1] = 1'b1; t_tab[1] = 32'h10;
        any_sel    = 1'b1;
        done_delay = 5;
        start_leaf(32'h200, 10, 32'h1000);
        wait_done();
        any_sel    = 1'b0;
        done_delay = 0;
        check("t8_issued", 64'(issued), 64'(3));
        check("t8_fewer", 64'(issued < 10), 64'(1));
        check("t8_hit", 64'(got_hit), 64'(1));
        check("t8_t", 64'(got_t), 64'h10);
        check("t8_prim", 64'(got_prim), 64'h201);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
